// File: rtl/io_pad_pkg.sv
// Shared constants and types for the user IO pad configuration controller.
package io_pad_pkg;

  // Per-pad configuration word layout.
  localparam int unsigned CFG_W  = 6;
  localparam int unsigned CFG_IE = 0;
  localparam int unsigned CFG_PU = 1;
  localparam int unsigned CFG_PD = 2;
  localparam int unsigned CFG_SL = 3;
  localparam int unsigned CFG_CS = 4;
  localparam int unsigned CFG_OE = 5;

  // Pads come out of reset as input-only.
  localparam logic [CFG_W-1:0] CFG_RESET = 6'b000001;

  // Command opcodes.
  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_READ_SH  = 2'd1;
  localparam logic [1:0] OP_COMMIT   = 2'd2;
  localparam logic [1:0] OP_READ_ACT = 2'd3;

  // Commit walker states.
  typedef enum logic [1:0] {
    IDLE,
    WALK,
    DONE
  } state_e;

  // Pull-up and pull-down together would fight on the pad.
  function automatic logic cfg_pupd_conflict(input logic [CFG_W-1:0] word);
    return word[CFG_PU] & word[CFG_PD];
  endfunction

endpackage

// File: rtl/io_in_sync.sv
// Two-flop synchronizer for the asynchronous pad inputs.
module io_in_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  // Shift pad inputs through two flops before any logic consumes them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_pad_ctrl.sv
// Per-pad configuration and staggered-commit controller for the user IOs.
// Holds shadow and active config words per pad; a COMMIT copies shadow to
// active one pad every STAGGER cycles to limit simultaneous switching.
// Build option: define IO_PAD_IN_SYNC_EN to pass io_in through a two-flop
// synchronizer (2-cycle input latency); otherwise io_in is used directly.
module io_pad_ctrl
  import io_pad_pkg::*;
#(
  parameter int unsigned NUM_IO  = 43,
  parameter int unsigned STAGGER = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Command interface
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [1:0]        cfg_op_i,
  input  logic [5:0]        cfg_idx_i,
  input  logic [CFG_W-1:0]  cfg_data_i,
  output logic              rd_valid_o,
  output logic [CFG_W-1:0]  rd_data_o,
  output logic              cfg_err_o,
  output logic              commit_done_o,
  // Core side
  input  logic [NUM_IO-1:0] core_out_i,
  input  logic [NUM_IO-1:0] core_oe_i,
  output logic [NUM_IO-1:0] in_o,
  // Pad side
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oe,
  output logic [NUM_IO-1:0] io_cs,
  output logic [NUM_IO-1:0] io_sl,
  output logic [NUM_IO-1:0] io_pu,
  output logic [NUM_IO-1:0] io_pd,
  output logic [NUM_IO-1:0] io_ie,
  input  logic [NUM_IO-1:0] io_in
);

  localparam int unsigned    StagW    = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam logic [StagW-1:0] StagLast = StagW'(STAGGER - 1);
  localparam logic [5:0]     PadLast  = 6'(NUM_IO - 1);

  state_e             state_q, state_d;
  logic [5:0]         pad_q, pad_d;
  logic [StagW-1:0]   stag_q, stag_d;
  logic               commit_wr;

  logic [CFG_W-1:0]   shadow_q [NUM_IO];
  logic [CFG_W-1:0]   active_q [NUM_IO];

  logic               rd_valid_q;
  logic [CFG_W-1:0]   rd_data_q;
  logic               err_q;

  logic               accept;
  logic               idx_ok;
  logic               is_write;
  logic               is_read;
  logic               wr_ok;
  logic               err_d;
  logic [CFG_W-1:0]   rd_word;

  logic [NUM_IO-1:0]  in_sampled;

  // Commands are only taken while the walker is idle.
  assign cfg_ready_o = (state_q == IDLE);
  assign accept      = cfg_valid_i & cfg_ready_o;
  assign idx_ok      = (32'(cfg_idx_i) < NUM_IO);
  assign is_write    = (cfg_op_i == OP_WRITE);
  assign is_read     = (cfg_op_i == OP_READ_SH) | (cfg_op_i == OP_READ_ACT);
  assign wr_ok       = accept & is_write & idx_ok & ~cfg_pupd_conflict(cfg_data_i);
  assign err_d       = accept & ((is_write & (~idx_ok | cfg_pupd_conflict(cfg_data_i))) |
                                 (is_read & ~idx_ok));

  // Select the addressed shadow or active word; out-of-range indices read 0.
  always_comb begin
    rd_word = '0;
    for (int n = 0; n < NUM_IO; n++) begin
      if (cfg_idx_i == 6'(n)) begin
        rd_word = (cfg_op_i == OP_READ_ACT) ? active_q[n] : shadow_q[n];
      end
    end
  end

  // Walker state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pad_q   <= '0;
      stag_q  <= '0;
    end else begin
      state_q <= state_d;
      pad_q   <= pad_d;
      stag_q  <= stag_d;
    end
  end

  // Walker next state: one slot of STAGGER cycles per pad, copy on slot entry.
  always_comb begin
    state_d       = state_q;
    pad_d         = pad_q;
    stag_d        = stag_q;
    commit_wr     = 1'b0;
    commit_done_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && (cfg_op_i == OP_COMMIT)) begin
          state_d = WALK;
          pad_d   = '0;
          stag_d  = StagLast;
        end
      end
      WALK: begin
        // Counter still at its reload value marks the first cycle of the slot.
        commit_wr = (stag_q == StagLast);
        if (stag_q == '0) begin
          stag_d = StagLast;
          if (pad_q == PadLast) begin
            state_d = DONE;
          end else begin
            pad_d = pad_q + 6'd1;
          end
        end else begin
          stag_d = stag_q - StagW'(1);
        end
      end
      DONE: begin
        commit_done_o = 1'b1;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Config storage and registered command responses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int n = 0; n < NUM_IO; n++) begin
        shadow_q[n] <= CFG_RESET;
        active_q[n] <= CFG_RESET;
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_IO; n++) begin
        if (wr_ok && (cfg_idx_i == 6'(n))) begin
          shadow_q[n] <= cfg_data_i;
        end
        if (commit_wr && (pad_q == 6'(n))) begin
          active_q[n] <= shadow_q[n];
        end
      end
      rd_valid_q <= accept & is_read;
      if (accept && is_read) begin
        rd_data_q <= rd_word;
      end
      err_q <= err_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign cfg_err_o  = err_q;

  // Fan the active words out to the pad control vectors.
  always_comb begin
    io_oe = '0;
    io_cs = '0;
    io_sl = '0;
    io_pu = '0;
    io_pd = '0;
    io_ie = '0;
    for (int n = 0; n < NUM_IO; n++) begin
      io_oe[n] = active_q[n][CFG_OE] & core_oe_i[n];
      io_cs[n] = active_q[n][CFG_CS];
      io_sl[n] = active_q[n][CFG_SL];
      io_pu[n] = active_q[n][CFG_PU];
      io_pd[n] = active_q[n][CFG_PD];
      io_ie[n] = active_q[n][CFG_IE];
    end
  end

  assign io_out = core_out_i;

`ifdef IO_PAD_IN_SYNC_EN
  io_in_sync #(
    .Width (NUM_IO)
  ) u_in_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (io_in),
    .q_o   (in_sampled)
  );
`else
  assign in_sampled = io_in;
`endif

  // Inputs are masked by ie and held at 0 while reset is asserted.
  assign in_o = in_sampled & io_ie & {NUM_IO{~rst_i}};

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Self-checking bench for io_pad_ctrl with STAGGER = 3: directed cases with
// literal expectations plus randomized traffic against a behavioural model.
module tb_io_pad_ctrl;

  localparam int N        = 43;
  localparam int S        = 3;
  localparam int WALK_END = N * S;

  localparam logic [1:0] OpWr   = 2'd0;
  localparam logic [1:0] OpRdSh = 2'd1;
  localparam logic [1:0] OpCmt  = 2'd2;
  localparam logic [1:0] OpRdAc = 2'd3;

  logic         clk;
  logic         rst_i;
  logic         cfg_valid_i;
  logic         cfg_ready_o;
  logic [1:0]   cfg_op_i;
  logic [5:0]   cfg_idx_i;
  logic [5:0]   cfg_data_i;
  logic         rd_valid_o;
  logic [5:0]   rd_data_o;
  logic         cfg_err_o;
  logic         commit_done_o;
  logic [N-1:0] core_out_i;
  logic [N-1:0] core_oe_i;
  logic [N-1:0] in_o;
  logic [N-1:0] io_out, io_oe, io_cs, io_sl, io_pu, io_pd, io_ie;
  logic [N-1:0] io_in;

  io_pad_ctrl #(
    .NUM_IO  (N),
    .STAGGER (S)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_ready_o   (cfg_ready_o),
    .cfg_op_i      (cfg_op_i),
    .cfg_idx_i     (cfg_idx_i),
    .cfg_data_i    (cfg_data_i),
    .rd_valid_o    (rd_valid_o),
    .rd_data_o     (rd_data_o),
    .cfg_err_o     (cfg_err_o),
    .commit_done_o (commit_done_o),
    .core_out_i    (core_out_i),
    .core_oe_i     (core_oe_i),
    .in_o          (in_o),
    .io_out        (io_out),
    .io_oe         (io_oe),
    .io_cs         (io_cs),
    .io_sl         (io_sl),
    .io_pu         (io_pu),
    .io_pd         (io_pd),
    .io_ie         (io_ie),
    .io_in         (io_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic rand_pads = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0]   sh  [N];
  logic [5:0]   act [N];
  int           age = -1;  // cycles since COMMIT accept, -1 when idle
  logic         m_rd_valid = 1'b0;
  logic [5:0]   m_rd_data  = '0;
  logic         m_err      = 1'b0;
  logic         m_acc;
  logic [N-1:0] s1 = '0, s2 = '0;

  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) begin
        sh[i]  = 6'b000001;
        act[i] = 6'b000001;
      end
      age = -1;
      m_rd_valid = 1'b0;
      m_rd_data  = '0;
      m_err      = 1'b0;
      s1 = '0;
      s2 = '0;
    end else begin
      m_acc = cfg_valid_i && (age < 0);
      // Pad k is copied at the end of cycle 1 + k*S.
      if (age >= 1) begin
        if (age <= WALK_END && ((age - 1) % S) == 0) act[(age-1)/S] = sh[(age-1)/S];
        age = (age == WALK_END + 1) ? -1 : age + 1;
      end
      m_rd_valid = 1'b0;
      m_err      = 1'b0;
      if (m_acc) begin
        case (cfg_op_i)
          OpWr: begin
            if (int'(cfg_idx_i) < N && !(cfg_data_i[1] && cfg_data_i[2]))
              sh[cfg_idx_i] = cfg_data_i;
            else
              m_err = 1'b1;
          end
          OpRdSh, OpRdAc: begin
            m_rd_valid = 1'b1;
            if (int'(cfg_idx_i) < N) begin
              m_rd_data = (cfg_op_i == OpRdSh) ? sh[cfg_idx_i] : act[cfg_idx_i];
            end else begin
              m_rd_data = '0;
              m_err = 1'b1;
            end
          end
          default: age = 1;
        endcase
      end
      s2 = s1;
      s1 = io_in;
    end
  end

  function automatic logic [N-1:0] fld(input int b);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = act[i][b];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_in();
    logic [N-1:0] src;
`ifdef IO_PAD_IN_SYNC_EN
    src = s2;
`else
    src = io_in;
`endif
    return rst_i ? '0 : (src & fld(0));
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready", cfg_ready_o, age < 0);
      check("done", commit_done_o, age == WALK_END + 1);
      check("rd_valid", rd_valid_o, m_rd_valid);
      check("err", cfg_err_o, m_err);
      if (m_rd_valid) check("rd_data", rd_data_o, m_rd_data);
      check("io_out", io_out, core_out_i);
      check("io_oe", io_oe, fld(5) & core_oe_i);
      check("io_cs", io_cs, fld(4));
      check("io_sl", io_sl, fld(3));
      check("io_pu", io_pu, fld(1));
      check("io_pd", io_pd, fld(2));
      check("io_ie", io_ie, fld(0));
      check("in_o", in_o, exp_in());
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] r64;
  always @(posedge clk) begin
    if (rand_pads) begin
      #1;
      r64 = {$urandom, $urandom}; core_out_i = r64[N-1:0];
      r64 = {$urandom, $urandom}; core_oe_i  = r64[N-1:0];
      r64 = {$urandom, $urandom}; io_in      = r64[N-1:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; returns in the cycle after it is accepted.
  task automatic cmd(input logic [1:0] op, input logic [5:0] idx, input logic [5:0] data);
    int w;
    w = 0;
    cfg_valid_i = 1'b1;
    cfg_op_i    = op;
    cfg_idx_i   = idx;
    cfg_data_i  = data;
    while (!cfg_ready_o && w < 300) begin
      tick();
      w++;
    end
    check("cmd_ready", cfg_ready_o, 1'b1);
    tick();
    cfg_valid_i = 1'b0;
  endtask

  int c;
  int done_cnt;
  int sel;

  initial begin
    rst_i = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_op_i = '0;
    cfg_idx_i = '0;
    cfg_data_i = '0;
    core_out_i = '0;
    core_oe_i = '0;
    io_in = '0;

    // Reset
    tick();
    tick();
    rst_i = 1'b0;
    chk_en = 1'b1;
    check("rst_ie", io_ie, {N{1'b1}});
    check("rst_oe", io_oe, '0);
    check("rst_pu_pd_sl_cs", {io_pu, io_pd, io_sl, io_cs} != '0, 1'b0);
    check("rst_ready", cfg_ready_o, 1'b1);
    check("rst_rd_valid", rd_valid_o, 1'b0);
    rand_pads = 1'b1;

    // Write, read back, commit with stagger timing
    cmd(OpWr, 6'd5, 6'b100011);
    cmd(OpRdSh, 6'd5, 6'd0);
    check("rdsh5_valid", rd_valid_o, 1'b1);
    check("rdsh5_data", rd_data_o, 6'b100011);
    cmd(OpRdAc, 6'd5, 6'd0);
    check("rdac5_data", rd_data_o, 6'b000001);
    cmd(OpWr, 6'd0, 6'b000010);
    cmd(OpWr, 6'd1, 6'b000100);
    cmd(OpCmt, 6'd63, 6'b111111);
    for (c = 1; c <= WALK_END + 2; c++) begin
      if (c == 1) check("pad0_before", io_pu[0], 1'b0);
      if (c == 2) check("pad0_after", io_pu[0], 1'b1);
      if (c == 4) check("pad1_before", io_pd[1], 1'b0);
      if (c == 5) check("pad1_after", io_pd[1], 1'b1);
      if (c == 17) begin
        check("pad5_pu", io_pu[5], 1'b1);
        check("pad5_oe", io_oe[5], core_oe_i[5]);
      end
      if (c == WALK_END) check("done_early", commit_done_o, 1'b0);
      if (c == WALK_END + 1) begin
        check("done_130", commit_done_o, 1'b1);
        check("ready_130", cfg_ready_o, 1'b0);
      end
      if (c == WALK_END + 2) check("ready_131", cfg_ready_o, 1'b1);
      if (c < WALK_END + 2) tick();
    end

    // Illegal commands
    cmd(OpWr, 6'd43, 6'b000010);
    check("wr43_err", cfg_err_o, 1'b1);
    cmd(OpWr, 6'd2, 6'b000111);
    check("wr_pupd_err", cfg_err_o, 1'b1);
    cmd(OpRdSh, 6'd2, 6'd0);
    check("rdsh2_data", rd_data_o, 6'b000001);
    check("rdsh2_noerr", cfg_err_o, 1'b0);
    cmd(OpRdAc, 6'd50, 6'd0);
    check("rd50_valid", rd_valid_o, 1'b1);
    check("rd50_data", rd_data_o, 6'd0);
    check("rd50_err", cfg_err_o, 1'b1);

    // Reset mid-commit
    cmd(OpWr, 6'd10, 6'b010001);
    cmd(OpCmt, 6'd0, 6'd0);
    for (c = 1; c < 20; c++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      if (commit_done_o) done_cnt++;
      tick();
    end
    check("no_done_after_rst", done_cnt, 0);
    for (int i = 0; i < N; i++) begin
      cmd(OpRdAc, 6'(i), 6'd0);
      check("act_after_rst", rd_data_o, 6'b000001);
    end
    cmd(OpRdSh, 6'd10, 6'd0);
    check("sh10_after_rst", rd_data_o, 6'b000001);

    // Input masking
    rand_pads = 1'b0;
    io_in = {N{1'b1}};
    cmd(OpWr, 6'd7, 6'b000000);
    cmd(OpCmt, 6'd0, 6'd0);
    for (int i = 0; i < WALK_END + 5; i++) tick();
    check("in7_masked", in_o[7], 1'b0);
    check("in8_pass", in_o[8], 1'b1);
    io_in[8] = 1'b0;
`ifdef IO_PAD_IN_SYNC_EN
    tick();
    check("in8_lat1", in_o[8], 1'b1);
    tick();
    check("in8_lat2", in_o[8], 1'b0);
`else
    #1;
    check("in8_lat0", in_o[8], 1'b0);
    tick();
`endif

    // Randomized traffic
    rand_pads = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      rst_i       = ($urandom_range(0, 999) == 0);
      cfg_valid_i = 1'($urandom_range(0, 1));
      sel         = int'($urandom_range(0, 99));
      if (sel < 4) cfg_op_i = OpCmt;
      else if (sel < 40) cfg_op_i = OpWr;
      else if (sel < 70) cfg_op_i = OpRdSh;
      else cfg_op_i = OpRdAc;
      cfg_idx_i  = 6'($urandom_range(0, 47));
      cfg_data_i = 6'($urandom_range(0, 63));
      tick();
    end
    rst_i = 1'b0;
    cfg_valid_i = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
